// File: rtl/store_unit.sv
// Store path: sb/sh/sw into word-wide data BRAM (sub-word via read-modify-write) or the MMIO page.
// Optional STORE_WSTRB_EN: byte-lane strobes replace read-modify-write for sub-word stores.
module store_unit #(
  parameter int          ADDR_W  = 14,
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter int          MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [2:0]        req_funct3,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef STORE_WSTRB_EN
  output logic [3:0]        mem_wstrb,
`endif
  input  logic [31:0]       mem_rdata,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_wdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_IOWR, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane_q;
  logic [1:0]  cnt_q;
  logic        half_q;
  logic        err_q;
  logic [15:0] data_q;
  logic        accept, bad, io_hit, is_sw;
  logic [31:0] merged;

  assign req_ready = rst & (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign is_sw     = (req_funct3 == 3'b010);
  assign bad       = (req_funct3 > 3'b010)
                   | ((req_funct3 == 3'b001) & req_addr[0])
                   | (is_sw & (req_addr[1:0] != 2'b00));
  assign io_hit    = (req_addr[31:10] == IO_BASE[31:10]);

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    io_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        // Misalignment wins over the IO decode so a bad MMIO store never strobes.
        if (accept) begin
          if (bad)         state_nxt = S_DONE;
          else if (io_hit) state_nxt = S_IOWR;
`ifdef STORE_WSTRB_EN
          else             state_nxt = S_WRITE;
`else
          else if (is_sw)  state_nxt = S_WRITE;
          else             state_nxt = S_READ;
`endif
        end
      end
      S_READ: begin
        mem_en    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = S_DONE;
      end
      S_IOWR: begin
        io_we     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (half_q) merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    else        merged[{lane_q, 3'b000} +: 8]      = data_q[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      lane_q    <= 2'd0;
      cnt_q     <= 2'd0;
      half_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 16'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      io_addr   <= 8'd0;
      io_wdata  <= 32'd0;
`ifdef STORE_WSTRB_EN
      mem_wstrb <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        lane_q <= req_addr[1:0];
        half_q <= (req_funct3 == 3'b001);
        err_q  <= bad;
        data_q <= req_data[15:0];
        if (!bad && io_hit) begin
          io_addr <= req_addr[9:2];
          case (req_funct3)
            3'b000:  io_wdata <= {24'd0, req_data[7:0]};
            3'b001:  io_wdata <= {16'd0, req_data[15:0]};
            default: io_wdata <= req_data;
          endcase
        end else if (!bad) begin
          mem_addr <= req_addr[ADDR_W+1:2];
`ifdef STORE_WSTRB_EN
          case (req_funct3)
            3'b000: begin
              mem_wdata <= {4{req_data[7:0]}};
              mem_wstrb <= 4'b0001 << req_addr[1:0];
            end
            3'b001: begin
              mem_wdata <= {2{req_data[15:0]}};
              mem_wstrb <= 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
              mem_wdata <= req_data;
              mem_wstrb <= 4'b1111;
            end
          endcase
`else
          mem_wdata <= req_data;
`endif
        end
      end
      // Read data is valid on the last WAIT cycle; merge it into the write word there.
      if (state == S_READ) begin
        cnt_q <= 2'(MEM_LAT - 1);
      end else if (state == S_WAIT) begin
        if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
        else               mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: byte-level reference memory, BRAM model, random + directed stores.
module tb_store_unit;
  localparam int ADDR_W  = 14;
  localparam int MEM_LAT = 1;
`ifdef STORE_WSTRB_EN
  localparam bit WSTRB = 1'b1;
`else
  localparam bit WSTRB = 1'b0;
`endif
  localparam int EV_RD = 0, EV_WR = 1, EV_IO = 2, EV_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_data = 32'd0;
  logic [2:0]        req_funct3 = 3'd0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              io_we;
  logic [7:0]        io_addr;
  logic [31:0]       io_wdata;
  logic              done, err;
  logic [3:0]        wstrb_obs;
`ifdef STORE_WSTRB_EN
  logic [3:0]        mem_wstrb;
  assign wstrb_obs = mem_wstrb;
`else
  assign wstrb_obs = 4'hF;
`endif

  store_unit #(.ADDR_W(ADDR_W), .IO_BASE(32'hFFFFFC00), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef STORE_WSTRB_EN
    .mem_wstrb(mem_wstrb),
`endif
    .mem_rdata(mem_rdata),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // BRAM model, one cycle read latency
  logic [31:0] bram [0:(1<<ADDR_W)-1] = '{default: 32'h0};
  logic [31:0] rdata_q = 32'h0;
  assign mem_rdata = rdata_q;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= apply_strb(bram[mem_addr], mem_wdata, wstrb_obs);
      else        rdata_q <= bram[mem_addr];
    end
  end

  // Reference memory: word index -> contents, absent words read as zero
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } ev_t;
  ev_t exp_q[$];

  function automatic void push(input int k, input int c, input logic [31:0] a, input logic [31:0] d, input logic e);
    ev_t ev;
    ev.kind = k; ev.cyc = c; ev.a = a; ev.d = d; ev.e = e;
    exp_q.push_back(ev);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int t, acc, size, w, pos;
    logic bad, io;
    logic [31:0] word, mask;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_funct3 = f3;
    t = 0;
    while (!req_ready && t < 64) begin @(negedge clk); t++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL accept_timeout got=ready_low exp=ready_high addr=%h", a);
      return;
    end
    acc  = cyc;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    if (size == 0) bad = 1'b1;
    else           bad = (a % size) != 0;
    io   = (a >> 10) == (32'hFFFFFC00 >> 10);
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    if (bad) begin
      push(EV_DONE, acc + 1, 32'h0, 32'h0, 1'b1);
    end else if (io) begin
      push(EV_IO, acc + 1, (a >> 2) & 32'hFF, d & mask, 1'b0);
      push(EV_DONE, acc + 2, 32'h0, 32'h0, 1'b0);
    end else begin
      w = int'((a >> 2) & 32'h3FFF);
      word = ref_rd(w);
      for (int i = 0; i < size; i++) begin
        pos  = int'(a % 4) + i;
        word = (word & ~(32'hFF << (8 * pos))) | (((d >> (8 * i)) & 32'hFF) << (8 * pos));
      end
      ref_mem[w] = word;
      if (size == 4 || WSTRB) begin
        push(EV_WR, acc + 1, w, word, 1'b0);
        push(EV_DONE, acc + 2, 32'h0, 32'h0, 1'b0);
      end else begin
        push(EV_RD, acc + 1, w, 32'h0, 1'b0);
        push(EV_WR, acc + 2 + MEM_LAT, w, word, 1'b0);
        push(EV_DONE, acc + 3 + MEM_LAT, 32'h0, 32'h0, 1'b0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_quiet(input logic exp_ready);
    chk("q_mem_en", mem_en, 0);     chk("q_mem_we", mem_we, 0);
    chk("q_io_we", io_we, 0);       chk("q_done", done, 0);
    chk("q_err", err, 0);           chk("q_mem_addr", 32'(mem_addr), 0);
    chk("q_mem_wdata", mem_wdata, 0); chk("q_io_addr", 32'(io_addr), 0);
    chk("q_io_wdata", io_wdata, 0); chk("q_req_ready", req_ready, 32'(exp_ready));
  endtask

  // Monitor: every bus event or completion must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst && (mem_en || io_we || done || err)) begin
      int k;
      ev_t ev;
      k = !mem_en ? (io_we ? EV_IO : EV_DONE) : (mem_we ? EV_WR : EV_RD);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event kind=%0d cycle=%0d exp=none", k, cyc);
      end else begin
        ev = exp_q.pop_front();
        chk("event_kind", k, ev.kind);
        chk("event_cycle", cyc, ev.cyc);
        case (ev.kind)
          EV_RD: chk("rd_addr", 32'(mem_addr), ev.a);
          EV_WR: begin
            chk("wr_addr", 32'(mem_addr), ev.a);
            chk("wr_word", apply_strb(bram[mem_addr], mem_wdata, wstrb_obs), ev.d);
          end
          EV_IO: begin
            chk("io_addr", 32'(io_addr), ev.a);
            chk("io_wdata", io_wdata, ev.d);
          end
          default: begin
            chk("done_pulse", done, 1);
            chk("done_err", err, 32'(ev.e));
          end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    repeat (3) @(negedge clk);
    #1 chk_quiet(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_after_reset", req_ready, 1);

    issue(32'h10, 32'h11223344, 3'b010);
    issue(32'h12, 32'h000000AB, 3'b000);
    drain();
    chk("bram_w4_sb_merge", bram[4], 32'h11AB3344);

    issue(32'h10, 32'hDEADBEEF, 3'b010);
    issue(32'h13, 32'h00001234, 3'b001);
    issue(32'h0E, 32'h00001234, 3'b010);
    issue(32'h20, 32'h55555555, 3'b011);
    issue(32'hFFFFFC60, 32'hFFFFFF80, 3'b000);
    issue(32'h22, 32'h0000BEEF, 3'b001);
    drain();
    chk("bram_w4_sw", bram[4], 32'hDEADBEEF);
    chk("bram_w8_sh", bram[8], 32'hBEEF0000);

    // Reset in the middle of a sub-word store: the write must never land
    saved = ref_rd(16);
    issue(32'h40, 32'h0000005A, 3'b000);
    if (!WSTRB) @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    ref_mem[16] = saved;
    #1 chk_quiet(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_after_abort", req_ready, 1);
    chk("abort_no_write", bram[16], saved);
    issue(32'h40, 32'hCAFEF00D, 3'b010);
    drain();
    chk("bram_w16_after_abort", bram[16], 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d;
      logic [2:0]  f3;
      int          r;
      r  = $urandom_range(0, 99);
      d  = $urandom;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (r < 15)      a = {22'h3FFFFF, 10'($urandom)};
      else if (r < 30) a = $urandom;
      else             a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(a, d, f3);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
